// File: rtl/data_ram_arb_pkg.sv
// Shared definitions for the two-master data RAM access controller.
package data_ram_arb_pkg;

    // Default RAM geometry: 256 words of 16 bits.
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 16;

    // Master identifiers, also used as the grant id and priority pointer value.
    localparam logic M_CPU = 1'b0;
    localparam logic M_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } arb_state_e;

    // The pointer always hands priority to whichever master was not just served.
    function automatic logic other_master(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Master-side request/ack bus plus the RAM port bundle of the data RAM arbiter.
interface data_ram_arbiter_if
    import data_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    // Master 0: CPU load/store unit
    logic              i_m0_req;
    logic              i_m0_we;
    logic [ADDR_W-1:0] i_m0_addr;
    logic [DATA_W-1:0] i_m0_wdata;
    logic              o_m0_ack;
    logic [DATA_W-1:0] o_m0_rdata;

    // Master 1: program/data loader
    logic              i_m1_req;
    logic              i_m1_we;
    logic [ADDR_W-1:0] i_m1_addr;
    logic [DATA_W-1:0] i_m1_wdata;
    logic              o_m1_ack;
    logic [DATA_W-1:0] o_m1_rdata;

    // RAM side
    logic              o_ram_ctrl_write;
    logic [ADDR_W-1:0] o_ram_addr_write;
    logic [DATA_W-1:0] o_ram_data_write;
    logic              o_ram_ctrl_read;
    logic [ADDR_W-1:0] o_ram_addr_read;
    logic [DATA_W-1:0] i_ram_data_read;

    logic              o_busy;

    // Arbiter view: consumes requests and RAM read data, drives everything else.
    modport slave (
        input  i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata,
        input  i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata,
        input  i_ram_data_read,
        output o_m0_ack, o_m0_rdata,
        output o_m1_ack, o_m1_rdata,
        output o_ram_ctrl_write, o_ram_addr_write, o_ram_data_write,
        output o_ram_ctrl_read, o_ram_addr_read,
        output o_busy
    );

    // Environment view: the two masters plus the RAM instance.
    modport master (
        output i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata,
        output i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata,
        output i_ram_data_read,
        input  o_m0_ack, o_m0_rdata,
        input  o_m1_ack, o_m1_rdata,
        input  o_ram_ctrl_write, o_ram_addr_write, o_ram_data_write,
        input  o_ram_ctrl_read, o_ram_addr_read,
        input  o_busy
    );

endinterface

// File: rtl/data_ram_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin picker. The pointer register lives in the parent.
module rr_arbiter2
    import data_ram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic       o_grant
);

    // A lone requester wins regardless of the pointer; on contention the pointer decides.
    always_comb begin
        o_grant = i_ptr;
        unique case (i_req)
            2'b01:   o_grant = M_CPU;
            2'b10:   o_grant = M_LDR;
            default: o_grant = i_ptr;
        endcase
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-master access controller for the data RAM: round-robin arbitration, a latched
// command issued to the RAM for one cycle, then a one-cycle ack to the winner.
module data_ram_arbiter
    import data_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter bit          RST_PTR = 1'b0
) (
    input logic               i_clk,
    input logic               i_rst,
    data_ram_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;

    // Command register: captured once in IDLE, immune to master input changes afterwards.
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              cmd_id_q, cmd_id_d;

    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0]        req;
    logic              grant;

    logic              ram_ctrl_write;
    logic [ADDR_W-1:0] ram_addr_write;
    logic [DATA_W-1:0] ram_data_write;
    logic              ram_ctrl_read;
    logic [ADDR_W-1:0] ram_addr_read;

    assign req = {bus.i_m1_req, bus.i_m0_req};

    rr_arbiter2 u_picker (
        .i_req   (req),
        .i_ptr   (ptr_q),
        .o_grant (grant)
    );

    // Next-state logic for the FSM, command register, acks, rdata and pointer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_id_d    = cmd_id_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    cmd_id_d = grant;
                    if (grant == M_LDR) begin
                        cmd_we_d    = bus.i_m1_we;
                        cmd_addr_d  = bus.i_m1_addr;
                        cmd_wdata_d = bus.i_m1_wdata;
                    end else begin
                        cmd_we_d    = bus.i_m0_we;
                        cmd_addr_d  = bus.i_m0_addr;
                        cmd_wdata_d = bus.i_m0_wdata;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // RAM read data is combinational, so it is valid on the closing edge.
                if (!cmd_we_q) begin
                    if (cmd_id_q == M_LDR) begin
                        rdata1_d = bus.i_ram_data_read;
                    end else begin
                        rdata0_d = bus.i_ram_data_read;
                    end
                end
                ack0_d  = (cmd_id_q == M_CPU);
                ack1_d  = (cmd_id_q == M_LDR);
                state_d = DONE;
            end
            DONE: begin
                ptr_d   = other_master(cmd_id_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset wins over any pending ack or capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ptr_q       <= RST_PTR;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_id_q    <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_id_q    <= cmd_id_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // RAM port gating: only the ISSUE cycle drives anything, and only one strobe.
    always_comb begin
        ram_ctrl_write = 1'b0;
        ram_addr_write = '0;
        ram_data_write = '0;
        ram_ctrl_read  = 1'b0;
        ram_addr_read  = '0;
        if (state_q == ISSUE) begin
            if (cmd_we_q) begin
                ram_ctrl_write = 1'b1;
                ram_addr_write = cmd_addr_q;
                ram_data_write = cmd_wdata_q;
            end else begin
                ram_ctrl_read = 1'b1;
                ram_addr_read = cmd_addr_q;
            end
        end
    end

    assign bus.o_ram_ctrl_write = ram_ctrl_write;
    assign bus.o_ram_addr_write = ram_addr_write;
    assign bus.o_ram_data_write = ram_data_write;
    assign bus.o_ram_ctrl_read  = ram_ctrl_read;
    assign bus.o_ram_addr_read  = ram_addr_read;

    assign bus.o_m0_ack   = ack0_q;
    assign bus.o_m1_ack   = ack1_q;
    assign bus.o_m0_rdata = rdata0_q;
    assign bus.o_m1_rdata = rdata1_q;
    assign bus.o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a 256 x 16 RAM model behind it.
module tb_data_ram_arbiter;

    logic clk;
    logic rst;

    int n_cmp = 0;
    int n_mis = 0;

    int strobe_viol = 0;
    int ack_viol    = 0;
    int gate_viol   = 0;

    data_ram_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    data_ram_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (16),
        .RST_PTR (1'b0)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, combinational read.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (bus.o_ram_ctrl_write) mem[bus.o_ram_addr_write] <= bus.o_ram_data_write;
    end
    assign bus.i_ram_data_read = mem[bus.o_ram_addr_read];

    // Continuous protocol watch: exclusive strobes, exclusive acks, RAM outputs idle
    // whenever the arbiter is in IDLE (not busy) or DONE (ack high).
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_ram_ctrl_write && bus.o_ram_ctrl_read) strobe_viol++;
            if (bus.o_m0_ack && bus.o_m1_ack) ack_viol++;
            if ((!bus.o_busy || bus.o_m0_ack || bus.o_m1_ack) &&
                (bus.o_ram_ctrl_write || bus.o_ram_ctrl_read || (bus.o_ram_addr_write != 0) ||
                 (bus.o_ram_data_write != 0) || (bus.o_ram_addr_read != 0)))
                gate_viol++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int m, input logic req, input logic we, input logic [7:0] addr,
                         input logic [15:0] wdata);
        if (m == 0) begin
            bus.i_m0_req   = req;
            bus.i_m0_we    = we;
            bus.i_m0_addr  = addr;
            bus.i_m0_wdata = wdata;
        end else begin
            bus.i_m1_req   = req;
            bus.i_m1_we    = we;
            bus.i_m1_addr  = addr;
            bus.i_m1_wdata = wdata;
        end
    endtask

    // Cycles from the current negedge until an ack shows up; who = -1 on timeout.
    task automatic wait_ack(output int who, output int lat);
        who = -1;
        lat = 0;
        for (int i = 0; i < 12 && who < 0; i++) begin
            tick();
            lat++;
            if (bus.o_m0_ack) who = 0;
            else if (bus.o_m1_ack) who = 1;
        end
        if (who < 0) check_eq("ack_timeout", 32'd0, 32'd1);
    endtask

    // Single transaction from IDLE; ends at the negedge of the following IDLE cycle.
    task automatic xfer(input int m, input logic we, input logic [7:0] addr,
                        input logic [15:0] wdata, input string tag);
        int who;
        int lat;
        drive(m, 1'b1, we, addr, wdata);
        wait_ack(who, lat);
        check_eq({tag, "_who"}, who, m);
        check_eq({tag, "_lat"}, lat, 32'd2);
        drive(m, 1'b0, we, addr, wdata);
        tick();
    endtask

    logic        b2b_we [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  b2b_ad [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [15:0] b2b_wd [4] = '{16'h1111, 16'h2222, 16'h0000, 16'h0000};

    initial begin
        int who;
        int lat;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) tick();

        // Reset state
        check_eq("rst_busy", bus.o_busy, 0);
        check_eq("rst_acks", {bus.o_m1_ack, bus.o_m0_ack}, 0);
        check_eq("rst_m0_rdata", bus.o_m0_rdata, 0);
        check_eq("rst_m1_rdata", bus.o_m1_rdata, 0);
        check_eq("rst_strobes", {bus.o_ram_ctrl_write, bus.o_ram_ctrl_read}, 0);
        rst = 1'b0;

        // Contention right after reset: m0 first, then strict alternation, acks 3 apart.
        drive(0, 1'b1, 1'b1, 8'h30, 16'hA0A0);
        drive(1, 1'b1, 1'b1, 8'h31, 16'hB1B1);
        for (int k = 0; k < 4; k++) begin
            wait_ack(who, lat);
            check_eq("alt_who", who, k % 2);
            check_eq("alt_lat", lat, (k == 0) ? 2 : 3);
        end
        drive(0, 1'b0, 1'b1, 8'h30, 16'hA0A0);
        drive(1, 1'b0, 1'b1, 8'h31, 16'hB1B1);
        tick();

        // m0 write then reads
        xfer(0, 1'b1, 8'h10, 16'hBEEF, "m0_wr10");
        xfer(0, 1'b0, 8'h31, 16'h0000, "m0_rd31");
        check_eq("m0_rdata_31", bus.o_m0_rdata, 16'hB1B1);
        xfer(0, 1'b0, 8'h10, 16'h0000, "m0_rd10");
        check_eq("m0_rdata_10", bus.o_m0_rdata, 16'hBEEF);
        check_eq("m1_rdata_idle", bus.o_m1_rdata, 0);

        // m1 back-to-back at the address extremes, request held across acks
        drive(1, 1'b1, b2b_we[0], b2b_ad[0], b2b_wd[0]);
        for (int k = 0; k < 4; k++) begin
            wait_ack(who, lat);
            check_eq("b2b_who", who, 1);
            check_eq("b2b_lat", lat, (k == 0) ? 2 : 3);
            if (k == 2) check_eq("b2b_rd00", bus.o_m1_rdata, 16'h1111);
            if (k == 3) check_eq("b2b_rdff", bus.o_m1_rdata, 16'h2222);
            if (k < 3) drive(1, 1'b1, b2b_we[k+1], b2b_ad[k+1], b2b_wd[k+1]);
            else drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        end
        tick();

        // m0 read result held across a later write
        xfer(0, 1'b1, 8'h40, 16'hAAAA, "m0_wr40");
        xfer(0, 1'b0, 8'h40, 16'h0000, "m0_rd40");
        check_eq("m0_rdata_40", bus.o_m0_rdata, 16'hAAAA);
        xfer(0, 1'b1, 8'h06, 16'h0606, "m0_wr06");

        // Address/data change during ISSUE must not reach the RAM
        drive(0, 1'b1, 1'b1, 8'h05, 16'h5555);
        tick();
        check_eq("iss_busy", bus.o_busy, 1);
        check_eq("iss_strobes", {bus.o_ram_ctrl_write, bus.o_ram_ctrl_read}, 2'b10);
        check_eq("iss_addr", bus.o_ram_addr_write, 8'h05);
        drive(0, 1'b1, 1'b1, 8'h06, 16'h6666);
        #1;
        check_eq("iss_addr_hold", bus.o_ram_addr_write, 8'h05);
        check_eq("iss_data_hold", bus.o_ram_data_write, 16'h5555);
        check_eq("iss_rdata_keep", bus.o_m0_rdata, 16'hAAAA);
        tick();
        check_eq("done_ack0", bus.o_m0_ack, 1);
        check_eq("done_strobes", {bus.o_ram_ctrl_write, bus.o_ram_ctrl_read}, 0);
        drive(0, 1'b0, 1'b1, 8'h06, 16'h6666);
        tick();
        check_eq("after_wr_rdata", bus.o_m0_rdata, 16'hAAAA);
        xfer(0, 1'b0, 8'h05, 16'h0000, "m0_rd05");
        check_eq("m0_rdata_05", bus.o_m0_rdata, 16'h5555);
        xfer(0, 1'b0, 8'h06, 16'h0000, "m0_rd06");
        check_eq("m0_rdata_06", bus.o_m0_rdata, 16'h0606);

        // Reset during ISSUE of an m1 write; pointer currently favours m1
        drive(1, 1'b1, 1'b1, 8'h20, 16'h1234);
        tick();
        check_eq("rst_iss_strobe", bus.o_ram_ctrl_write, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 1'b0, 1'b1, 8'h20, 16'h1234);
        check_eq("post_rst_busy", bus.o_busy, 0);
        check_eq("post_rst_m0_rdata", bus.o_m0_rdata, 0);
        check_eq("post_rst_m1_rdata", bus.o_m1_rdata, 0);
        for (int k = 0; k < 3; k++) begin
            check_eq("post_rst_noack", {bus.o_m1_ack, bus.o_m0_ack}, 0);
            tick();
        end

        // Both read addr 0x20: m0 must win, proving the pointer returned to RST_PTR
        drive(0, 1'b1, 1'b0, 8'h20, 16'h0000);
        drive(1, 1'b1, 1'b0, 8'h20, 16'h0000);
        wait_ack(who, lat);
        check_eq("rst_ptr_who", who, 0);
        check_eq("rst_ptr_lat", lat, 2);
        check_eq("rst_wr_commit_m0", bus.o_m0_rdata, 16'h1234);
        drive(0, 1'b0, 1'b0, 8'h20, 16'h0000);
        wait_ack(who, lat);
        check_eq("rst_m1_who", who, 1);
        check_eq("rst_m1_lat", lat, 3);
        check_eq("rst_wr_commit_m1", bus.o_m1_rdata, 16'h1234);
        drive(1, 1'b0, 1'b0, 8'h20, 16'h0000);
        repeat (2) tick();

        check_eq("strobe_exclusive", strobe_viol, 0);
        check_eq("ack_exclusive", ack_viol, 0);
        check_eq("ram_gating", gate_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
